// File: rtl/pic_bus_initiator.sv
// ---------------------------------------------------------------------------
// pic_bus_initiator
//
// CPU-side initiator for the 8-bit XT peripheral bus (KF8259 and similar).
// It accepts one read or write request at a time and plays it onto the bus
// in three timed phases:
//   SETUP  : cs_n low, address (and write data) valid, strobes high
//   STROBE : read_enable_n or write_enable_n low
//   HOLD   : strobes high again, cs_n/address/data still valid
// When HOLD ends the block returns to IDLE and pulses done for one cycle.
// For reads, the byte on data_bus_in is captured on the last STROBE edge.
//
// Parameters
//   SETUP_CYCLES  cycles of SETUP before the strobe falls     (1..15)
//   PULSE_CYCLES  cycles the strobe is held low               (1..15)
//   HOLD_CYCLES   cycles of HOLD after the strobe rises       (1..15)
//                 At least 1 so the peripheral sees the write edge with
//                 cs_n still low.
//
// Ports
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   req_valid       request strobe from the register-access logic
//   req_ready       high in IDLE only
//   req_write       1 = write cycle, 0 = read cycle
//   req_address     peripheral A0
//   req_data        write data
//   done            one-cycle pulse in the first IDLE cycle after a transfer
//   read_data       byte captured by the most recent completed read
//   chip_select_n   peripheral chip select, active low
//   read_enable_n   read strobe, active low
//   write_enable_n  write strobe, active low
//   address         peripheral address
//   data_bus_out    write data toward the peripheral
//   data_bus_oe     high while data_bus_out is being driven
//   data_bus_in     read data from the peripheral
//
// Every bus pin comes straight from a flop; the req_* inputs only reach the
// pins through those flops.
// ---------------------------------------------------------------------------
module pic_bus_initiator #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_address,
    input  logic [7:0] req_data,
    output logic       done,
    output logic [7:0] read_data,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_oe,
    input  logic [7:0] data_bus_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The counter holds "cycles remaining in this phase minus one", so a
    // phase ends when it reads zero and each phase entry reloads N-1.
    localparam int          COUNT_W     = 4;
    localparam logic [COUNT_W-1:0] SETUP_LOAD = COUNT_W'(SETUP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] PULSE_LOAD = COUNT_W'(PULSE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] HOLD_LOAD  = COUNT_W'(HOLD_CYCLES - 1);

    state_t               state, state_next;
    logic [COUNT_W-1:0]   count, count_next;
    logic                 write_q, write_q_next;

    logic                 chip_select_n_next;
    logic                 read_enable_n_next;
    logic                 write_enable_n_next;
    logic                 address_next;
    logic [7:0]           data_bus_out_next;
    logic                 data_bus_oe_next;
    logic                 done_next;
    logic [7:0]           read_data_next;

    // Ready is a decode of the state flop, never of the request inputs.
    assign req_ready = (state == IDLE);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case statement leaves one unassigned and no latch is built.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next          = state;
        count_next          = count;
        write_q_next        = write_q;
        chip_select_n_next  = chip_select_n;
        read_enable_n_next  = read_enable_n;
        write_enable_n_next = write_enable_n;
        address_next        = address;
        data_bus_out_next   = data_bus_out;
        data_bus_oe_next    = data_bus_oe;
        read_data_next      = read_data;
        done_next           = 1'b0;

        unique case (state)
            IDLE: begin
                chip_select_n_next  = 1'b1;
                read_enable_n_next  = 1'b1;
                write_enable_n_next = 1'b1;
                data_bus_oe_next    = 1'b0;
                if (req_valid) begin
                    state_next         = SETUP;
                    count_next         = SETUP_LOAD;
                    write_q_next       = req_write;
                    chip_select_n_next = 1'b0;
                    address_next       = req_address;
                    data_bus_oe_next   = req_write;
                    // A read leaves the last write byte on data_bus_out;
                    // it is not driven anyway because oe stays low.
                    if (req_write) begin
                        data_bus_out_next = req_data;
                    end
                end
            end

            SETUP: begin
                if (count == '0) begin
                    state_next          = STROBE;
                    count_next          = PULSE_LOAD;
                    write_enable_n_next = ~write_q;
                    read_enable_n_next  = write_q;
                end else begin
                    count_next = count - 1'b1;
                end
            end

            STROBE: begin
                if (count == '0) begin
                    state_next          = HOLD;
                    count_next          = HOLD_LOAD;
                    write_enable_n_next = 1'b1;
                    read_enable_n_next  = 1'b1;
                    // This edge ends the strobe: the peripheral is still
                    // driving the byte, so it is captured here.
                    if (!write_q) begin
                        read_data_next = data_bus_in;
                    end
                end else begin
                    count_next = count - 1'b1;
                end
            end

            HOLD: begin
                if (count == '0) begin
                    state_next         = IDLE;
                    count_next         = '0;
                    chip_select_n_next = 1'b1;
                    data_bus_oe_next   = 1'b0;
                    done_next          = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers. Reset drops cs_n and both strobes to
    // their inactive level at once and abandons any transfer in flight.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of order.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            write_q        <= 1'b0;
            chip_select_n  <= 1'b1;
            read_enable_n  <= 1'b1;
            write_enable_n <= 1'b1;
            address        <= 1'b0;
            data_bus_out   <= 8'h00;
            data_bus_oe    <= 1'b0;
            done           <= 1'b0;
            read_data      <= 8'h00;
        end else begin
            state          <= state_next;
            count          <= count_next;
            write_q        <= write_q_next;
            chip_select_n  <= chip_select_n_next;
            read_enable_n  <= read_enable_n_next;
            write_enable_n <= write_enable_n_next;
            address        <= address_next;
            data_bus_out   <= data_bus_out_next;
            data_bus_oe    <= data_bus_oe_next;
            done           <= done_next;
            read_data      <= read_data_next;
        end
    end

endmodule

// File: tb/tb_pic_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_pic_bus_initiator
//
// Two lanes run in parallel on one clock: lane 0 uses the default timing
// (1/2/1), lane 1 uses SETUP=2, PULSE=1, HOLD=3. Each lane has
//   - a small peripheral with two byte registers that latches writes on the
//     rising write strobe (cs_n low) and drives its register onto
//     data_bus_in only while the read strobe is low (the inverted byte
//     otherwise, so a mistimed capture is visible);
//   - a driver that issues directed then random requests, pushing the
//     expected result of each accepted request into a scoreboard queue;
//   - a scoreboard monitor that pops on every done pulse;
//   - a cycle monitor that predicts every bus pin from the acceptance cycle
//     and the phase lengths.
// ---------------------------------------------------------------------------
module tb_pic_bus_initiator;

    typedef struct {
        bit         write;
        bit         addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } txn_t;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   lanes_done = 0;
    logic clk        = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int S   = (g == 0) ? 1 : 2;
        localparam int P   = (g == 0) ? 2 : 1;
        localparam int H   = (g == 0) ? 1 : 3;
        localparam int LAT = 1 + S + P + H;

        logic       rst_n;
        logic       req_valid, req_ready, req_write, req_address;
        logic [7:0] req_data;
        logic       done;
        logic [7:0] read_data;
        logic       cs_n, re_n, we_n, address, oe;
        logic [7:0] dout, din;

        logic [7:0] perif_mem [2] = '{8'h3C, 8'hC3};
        logic [7:0] mem_model [2] = '{8'h3C, 8'hC3};
        logic [7:0] last_rd       = 8'h00;
        txn_t       sb[$];

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", g, s);
        endfunction

        pic_bus_initiator #(
            .SETUP_CYCLES(S),
            .PULSE_CYCLES(P),
            .HOLD_CYCLES (H)
        ) dut (
            .clock         (clk),
            .reset_n       (rst_n),
            .req_valid     (req_valid),
            .req_ready     (req_ready),
            .req_write     (req_write),
            .req_address   (req_address),
            .req_data      (req_data),
            .done          (done),
            .read_data     (read_data),
            .chip_select_n (cs_n),
            .read_enable_n (re_n),
            .write_enable_n(we_n),
            .address       (address),
            .data_bus_out  (dout),
            .data_bus_oe   (oe),
            .data_bus_in   (din)
        );

        // Peripheral: valid read data only while the read strobe is low.
        assign din = (!re_n && !cs_n) ? perif_mem[address] : ~perif_mem[address];

        logic prev_we_n = 1'b1;
        always @(negedge clk) begin
            if (!prev_we_n && we_n && !cs_n) begin
                check(nm("oe at write edge"), 32'(oe), 32'd1);
                perif_mem[address] = dout;
            end
            prev_we_n = we_n;
        end

        // Scoreboard: one expected entry per accepted request.
        always @(negedge clk) begin
            txn_t t;
            if (!rst_n) begin
                sb.delete();
            end else if (done) begin
                if (sb.size() == 0) begin
                    check(nm("spurious done"), 32'(done), 32'd0);
                end else begin
                    t = sb.pop_front();
                    check(nm("read_data at done"), 32'(read_data), 32'(t.exp_rd));
                    if (t.write) begin
                        check(nm("peripheral write byte"), 32'(perif_mem[t.addr]), 32'(t.data));
                    end
                end
            end
        end

        // Cycle monitor: pins predicted from cycles elapsed since acceptance.
        bit         busy    = 1'b0;
        int         cyc     = 0;
        int         acc_cyc = 0;
        bit         cur_w, cur_a;
        logic [7:0] cur_d;
        always @(negedge clk) begin
            int k;
            bit active, strobe, fin;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                k      = cyc - acc_cyc;
                active = busy && (k >= 1) && (k <= S + P + H);
                strobe = busy && (k >= S + 1) && (k <= S + P);
                fin    = busy && (k == LAT);
                check(nm("cs_n"),           32'(cs_n),      32'(!active));
                check(nm("write_enable_n"), 32'(we_n),      32'(!(strobe && cur_w)));
                check(nm("read_enable_n"),  32'(re_n),      32'(!(strobe && !cur_w)));
                check(nm("data_bus_oe"),    32'(oe),        32'(active && cur_w));
                check(nm("done"),           32'(done),      32'(fin));
                check(nm("req_ready"),      32'(req_ready), 32'(!busy || fin));
                if (active) begin
                    check(nm("address"), 32'(address), 32'(cur_a));
                    if (cur_w) check(nm("data_bus_out"), 32'(dout), 32'(cur_d));
                end
                if (fin) busy = 1'b0;
                if (req_valid && req_ready) begin
                    busy    = 1'b1;
                    acc_cyc = cyc;
                    cur_w   = req_write;
                    cur_a   = req_address;
                    cur_d   = req_data;
                end
            end
            cyc++;
        end

        // Present a request until accepted; optionally keep req_valid high
        // with changing junk for the whole busy window afterwards.
        task automatic issue(input bit w, input bit a, input logic [7:0] d, input bit junk);
            txn_t t;
            bit   ok;
            ok          = 1'b0;
            req_valid   = 1'b1;
            req_write   = w;
            req_address = a;
            req_data    = d;
            for (int i = 0; i < 4 * LAT && !ok; i++) begin
                @(negedge clk);
                ok = req_ready;
            end
            if (!ok) begin
                check(nm("accept timeout"), 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
            t.write = w;
            t.addr  = a;
            t.data  = d;
            if (w) begin
                mem_model[a] = d;
                t.exp_rd     = last_rd;
            end else begin
                t.exp_rd = mem_model[a];
                last_rd  = mem_model[a];
            end
            sb.push_back(t);
            @(posedge clk);
            #1;
            if (junk) begin
                for (int i = 0; i < LAT - 1; i++) begin
                    req_write   = 1'($urandom);
                    req_address = 1'($urandom);
                    req_data    = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            req_valid = 1'b0;
        endtask

        initial begin
            rst_n       = 1'b1;
            req_valid   = 1'b0;
            req_write   = 1'b0;
            req_address = 1'b0;
            req_data    = 8'h00;
            #1 rst_n = 1'b0;
            #1;
            check(nm("reset cs_n"),         32'(cs_n),      32'd1);
            check(nm("reset re_n"),         32'(re_n),      32'd1);
            check(nm("reset we_n"),         32'(we_n),      32'd1);
            check(nm("reset address"),      32'(address),   32'd0);
            check(nm("reset data_bus_out"), 32'(dout),      32'h00);
            check(nm("reset oe"),           32'(oe),        32'd0);
            check(nm("reset done"),         32'(done),      32'd0);
            check(nm("reset read_data"),    32'(read_data), 32'h00);
            check(nm("reset req_ready"),    32'(req_ready), 32'd1);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;

            // Directed: ICW1 then back-to-back ICW2, read-backs, busy junk.
            issue(1'b1, 1'b0, 8'h13, 1'b0);
            issue(1'b1, 1'b1, 8'h08, 1'b0);
            issue(1'b0, 1'b1, 8'h00, 1'b0);
            issue(1'b0, 1'b0, 8'hFF, 1'b0);
            issue(1'b1, 1'b1, 8'h5A, 1'b1);
            issue(1'b0, 1'b1, 8'($urandom), 1'b1);

            // Random traffic with random gaps (zero gap = back-to-back).
            for (int n = 0; n < 120; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                issue(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
            end
            repeat (LAT + 2) @(posedge clk);
            #1;
            check(nm("scoreboard drained"), 32'(sb.size()), 32'd0);

            // Reset during the first STROBE cycle of a write.
            issue(1'b1, 1'b0, 8'hE7, 1'b0);
            repeat (S) @(posedge clk);
            #1;
            check(nm("strobe low before reset"), 32'(we_n), 32'd0);
            rst_n = 1'b0;
            #1;
            check(nm("mid reset we_n"), 32'(we_n), 32'd1);
            check(nm("mid reset re_n"), 32'(re_n), 32'd1);
            check(nm("mid reset cs_n"), 32'(cs_n), 32'd1);
            check(nm("mid reset oe"),   32'(oe),   32'd0);
            last_rd = 8'h00;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int i = 0; i < LAT + 2; i++) begin
                @(negedge clk);
                check(nm("post reset done"),      32'(done),      32'd0);
                check(nm("post reset req_ready"), 32'(req_ready), 32'd1);
                check(nm("post reset read_data"), 32'(read_data), 32'(last_rd));
            end
            lanes_done++;
        end
    end

    initial begin
        fork
            wait (lanes_done == 2);
            #400000;
        join_any
        check("lanes finished before time limit", 32'(lanes_done), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
